// File: rtl/plru_victim_select.sv
// Tree pseudo-LRU replacement for WAYS x SETS caches, with a registered victim (index, one-hot, line data).
// Victim latency 1 cycle, one request per cycle accepted, no backpressure.
module plru_victim_select #(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int WIDTH = 128,
  localparam int SW   = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WW   = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  access_valid,
  input  logic [SW-1:0]         access_set,
  input  logic [WW-1:0]         access_way,
  input  logic                  evict_req,
  input  logic [SW-1:0]         evict_set,
  input  logic [WAYS*WIDTH-1:0] way_data,
  output logic                  evict_valid,
  output logic [WW-1:0]         victim_way,
  output logic [WAYS-1:0]       victim_onehot,
  output logic [WIDTH-1:0]      victim_data
);

  localparam int NODES = WAYS - 1;

  logic [NODES-1:0] plru_q [SETS];
  logic [NODES-1:0] plru_d [SETS];
  logic [NODES-1:0] ev_bits;

  logic             evict_valid_q, evict_valid_d;
  logic [WW-1:0]    victim_way_q, victim_way_d;
  logic [WAYS-1:0]  victim_onehot_q, victim_onehot_d;
  logic [WIDTH-1:0] victim_data_q, victim_data_d;

  // Heap-ordered walk: bit 1 sends the victim search to the left (lower) child.
  function automatic logic [WW-1:0] tree_victim(input logic [NODES-1:0] bits);
    logic [WW-1:0] way;
    logic          b;
    int            node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++) begin
        if (n == node) b = bits[n];
      end
      way[WW-1-l] = ~b;
      node = b ? (2 * node + 1) : (2 * node + 2);
    end
    return way;
  endfunction

  // Each node on the path is pointed at the sibling subtree of the touched way.
  function automatic logic [NODES-1:0] tree_touch(input logic [NODES-1:0] bits,
                                                  input logic [WW-1:0]    way);
    logic [NODES-1:0] nb;
    int               node;
    nb   = bits;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      for (int n = 0; n < NODES; n++) begin
        if (n == node) nb[n] = way[WW-1-l];
      end
      node = way[WW-1-l] ? (2 * node + 2) : (2 * node + 1);
    end
    return nb;
  endfunction

  // Victim is read from plru_q, so a same-cycle access to that set is not yet visible.
  always_comb begin
    plru_d  = plru_q;
    ev_bits = '0;
    for (int s = 0; s < SETS; s++) begin
      if (access_valid && (SETS == 1 || s == int'(access_set))) begin
        plru_d[s] = tree_touch(plru_q[s], access_way);
      end
      if (SETS == 1 || s == int'(evict_set)) begin
        ev_bits = plru_q[s];
      end
    end
  end

  always_comb begin
    evict_valid_d   = evict_req;
    victim_way_d    = victim_way_q;
    victim_onehot_d = victim_onehot_q;
    victim_data_d   = victim_data_q;
    if (evict_req) begin
      victim_way_d = tree_victim(ev_bits);
      for (int w = 0; w < WAYS; w++) begin
        victim_onehot_d[w] = (w == int'(victim_way_d));
        if (w == int'(victim_way_d)) begin
          victim_data_d = way_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
      evict_valid_q   <= 1'b0;
      victim_way_q    <= '0;
      victim_onehot_q <= '0;
      victim_data_q   <= '0;
    end else begin
      plru_q          <= plru_d;
      evict_valid_q   <= evict_valid_d;
      victim_way_q    <= victim_way_d;
      victim_onehot_q <= victim_onehot_d;
      victim_data_q   <= victim_data_d;
    end
  end

  assign evict_valid   = evict_valid_q;
  assign victim_way    = victim_way_q;
  assign victim_onehot = victim_onehot_q;
  assign victim_data   = victim_data_q;

endmodule

// File: tb/tb_plru_victim_select.sv
// Bench for plru_victim_select: a 4-way/8-set/128-bit instance and an 8-way/4-set/16-bit instance.
module tb_plru_victim_select;

  typedef struct packed {
    logic [1:0]   way;
    logic [127:0] data;
  } exp_a_t;

  typedef struct packed {
    logic [2:0]  way;
    logic [15:0] data;
  } exp_b_t;

  logic clk;
  logic reset_n;

  logic         a_access_valid;
  logic [2:0]   a_access_set;
  logic [1:0]   a_access_way;
  logic         a_evict_req;
  logic [2:0]   a_evict_set;
  logic [511:0] a_way_data;
  logic         a_evict_valid;
  logic [1:0]   a_victim_way;
  logic [3:0]   a_victim_onehot;
  logic [127:0] a_victim_data;

  logic         b_access_valid;
  logic [1:0]   b_access_set;
  logic [2:0]   b_access_way;
  logic         b_evict_req;
  logic [1:0]   b_evict_set;
  logic [127:0] b_way_data;
  logic         b_evict_valid;
  logic [2:0]   b_victim_way;
  logic [7:0]   b_victim_onehot;
  logic [15:0]  b_victim_data;

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];
  int checks = 0;
  int errors = 0;

  plru_victim_select #(.WAYS(4), .SETS(8), .WIDTH(128)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .access_valid(a_access_valid), .access_set(a_access_set), .access_way(a_access_way),
    .evict_req(a_evict_req), .evict_set(a_evict_set), .way_data(a_way_data),
    .evict_valid(a_evict_valid), .victim_way(a_victim_way),
    .victim_onehot(a_victim_onehot), .victim_data(a_victim_data)
  );

  plru_victim_select #(.WAYS(8), .SETS(4), .WIDTH(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .access_valid(b_access_valid), .access_set(b_access_set), .access_way(b_access_way),
    .evict_req(b_evict_req), .evict_set(b_evict_set), .way_data(b_way_data),
    .evict_valid(b_evict_valid), .victim_way(b_victim_way),
    .victim_onehot(b_victim_onehot), .victim_data(b_victim_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_n        = 1'b0;
    a_access_valid = 1'b0; a_access_set = '0; a_access_way = '0;
    a_evict_req    = 1'b0; a_evict_set  = '0; a_way_data   = '0;
    b_access_valid = 1'b0; b_access_set = '0; b_access_way = '0;
    b_evict_req    = 1'b0; b_evict_set  = '0; b_way_data   = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic a_touch(input int s, input int w);
    @(negedge clk);
    a_access_valid = 1'b1; a_access_set = 3'(s); a_access_way = 2'(w);
    @(negedge clk);
    a_access_valid = 1'b0;
  endtask

  task automatic b_touch(input int s, input int w);
    @(negedge clk);
    b_access_valid = 1'b1; b_access_set = 2'(s); b_access_way = 3'(w);
    @(negedge clk);
    b_access_valid = 1'b0;
  endtask

  // Drives one request with fresh line data and records the expected victim.
  task automatic a_push_evict(input int s, input int w);
    exp_a_t e;
    for (int k = 0; k < 16; k++) a_way_data[k*32 +: 32] = $urandom();
    a_evict_req = 1'b1;
    a_evict_set = 3'(s);
    e.way  = 2'(w);
    e.data = a_way_data[w*128 +: 128];
    sb_a.push_back(e);
  endtask

  task automatic b_push_evict(input int s, input int w);
    exp_b_t e;
    for (int k = 0; k < 4; k++) b_way_data[k*32 +: 32] = $urandom();
    b_evict_req = 1'b1;
    b_evict_set = 2'(s);
    e.way  = 3'(w);
    e.data = b_way_data[w*16 +: 16];
    sb_b.push_back(e);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (a_evict_valid !== 1'b0) begin
      errors++; $display("FAIL reset_a_valid: got %b want 0", a_evict_valid);
    end
    checks++;
    if (a_victim_way !== 2'd0) begin
      errors++; $display("FAIL reset_a_way: got %0d want 0", a_victim_way);
    end
    checks++;
    if (a_victim_onehot !== 4'b0000) begin
      errors++; $display("FAIL reset_a_onehot: got %b want 0000", a_victim_onehot);
    end
    checks++;
    if (a_victim_data !== 128'd0) begin
      errors++; $display("FAIL reset_a_data: got %h want 0", a_victim_data);
    end
    checks++;
    if (b_evict_valid !== 1'b0 || b_victim_way !== 3'd0 || b_victim_onehot !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: got vld=%b way=%0d oh=%b want 0 0 0", b_evict_valid, b_victim_way, b_victim_onehot);
    end
  endtask

  task automatic test_default_victim();
    exp_a_t e;
    @(negedge clk);
    a_push_evict(0, 3);
    @(negedge clk);
    a_evict_req = 1'b0;
    e = sb_a.pop_front();
    checks++;
    if (a_evict_valid !== 1'b1 || a_victim_way !== e.way || a_victim_onehot !== (4'b0001 << e.way) || a_victim_data !== e.data) begin
      errors++;
      $display("FAIL default_victim: got vld=%b way=%0d oh=%b data=%h want way=%0d data=%h", a_evict_valid, a_victim_way, a_victim_onehot, a_victim_data, e.way, e.data);
    end
    for (int k = 0; k < 16; k++) a_way_data[k*32 +: 32] = $urandom();
    @(negedge clk);
    checks++;
    if (a_evict_valid !== 1'b0 || a_victim_way !== e.way || a_victim_onehot !== 4'b1000 || a_victim_data !== e.data) begin
      errors++;
      $display("FAIL hold_outputs: got vld=%b way=%0d oh=%b data=%h want vld=0 way=%0d data=%h", a_evict_valid, a_victim_way, a_victim_onehot, a_victim_data, e.way, e.data);
    end
  endtask

  task automatic test_access_order();
    int order[4] = '{3, 0, 2, 1};
    int sets[3]  = '{2, 0, 4};
    int exps[3]  = '{3, 3, 1};
    exp_a_t e;
    for (int i = 0; i < 4; i++) a_touch(2, order[i]);
    a_touch(4, 2);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb_a.pop_front();
        checks++;
        if (a_evict_valid !== 1'b1 || a_victim_way !== e.way || a_victim_onehot !== (4'b0001 << e.way) || a_victim_data !== e.data) begin
          errors++;
          $display("FAIL access_order[%0d]: got vld=%b way=%0d oh=%b data=%h want way=%0d data=%h", i-1, a_evict_valid, a_victim_way, a_victim_onehot, a_victim_data, e.way, e.data);
        end
      end
      if (i < 3) a_push_evict(sets[i], exps[i]);
      else a_evict_req = 1'b0;
    end
  endtask

  task automatic test_same_cycle();
    int sets[4] = '{5, 7, 5, 6};
    int exps[4] = '{3, 3, 1, 1};
    exp_a_t e;
    apply_reset();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      a_access_valid = 1'b0;
      if (i > 0) begin
        e = sb_a.pop_front();
        checks++;
        if (a_evict_valid !== 1'b1 || a_victim_way !== e.way || a_victim_onehot !== (4'b0001 << e.way) || a_victim_data !== e.data) begin
          errors++;
          $display("FAIL same_cycle[%0d]: got vld=%b way=%0d oh=%b data=%h want way=%0d data=%h", i-1, a_evict_valid, a_victim_way, a_victim_onehot, a_victim_data, e.way, e.data);
        end
      end
      // Steps 0 and 1 touch way 3 of sets 5 and 6 alongside the request.
      if (i < 2) begin
        a_access_valid = 1'b1;
        a_access_set   = (i == 0) ? 3'd5 : 3'd6;
        a_access_way   = 2'd3;
      end
      if (i < 4) a_push_evict(sets[i], exps[i]);
      else a_evict_req = 1'b0;
    end
  endtask

  task automatic test_ways8();
    int sets[3] = '{1, 1, 0};
    int exps[3] = '{0, 4, 7};
    exp_b_t e;
    for (int w = 0; w < 8; w++) b_touch(1, w);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) b_touch(1, 0);
      @(negedge clk);
      b_push_evict(sets[i], exps[i]);
      @(negedge clk);
      b_evict_req = 1'b0;
      e = sb_b.pop_front();
      checks++;
      if (b_evict_valid !== 1'b1 || b_victim_way !== e.way || b_victim_onehot !== (8'b1 << e.way) || b_victim_data !== e.data) begin
        errors++;
        $display("FAIL ways8[%0d]: got vld=%b way=%0d oh=%b data=%h want way=%0d data=%h", i, b_evict_valid, b_victim_way, b_victim_onehot, b_victim_data, e.way, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exps[3] = '{3, 1, 0};
    exp_a_t e;
    apply_reset();
    a_touch(1, 3);
    a_touch(2, 1);
    a_touch(2, 3);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb_a.pop_front();
        checks++;
        if (a_evict_valid !== 1'b1 || a_victim_way !== e.way || a_victim_onehot !== (4'b0001 << e.way) || a_victim_data !== e.data) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got vld=%b way=%0d oh=%b data=%h want way=%0d data=%h", i-1, a_evict_valid, a_victim_way, a_victim_onehot, a_victim_data, e.way, e.data);
        end
      end
      if (i < 3) a_push_evict(i, exps[i]);
      else a_evict_req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (a_evict_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_end: got vld=%b want 0", a_evict_valid);
    end
  endtask

  task automatic test_reset_drop();
    exp_a_t ea;
    exp_b_t eb;
    a_touch(3, 3);
    b_touch(2, 5);
    @(negedge clk);
    a_evict_req = 1'b1; a_evict_set = 3'd3;
    b_evict_req = 1'b1; b_evict_set = 2'd2;
    @(negedge clk);
    a_evict_req = 1'b0;
    b_evict_req = 1'b0;
    reset_n     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (a_evict_valid !== 1'b0 || a_victim_way !== 2'd0 || a_victim_data !== 128'd0) begin
      errors++;
      $display("FAIL drop_a: got vld=%b way=%0d data=%h want 0 0 0", a_evict_valid, a_victim_way, a_victim_data);
    end
    checks++;
    if (b_evict_valid !== 1'b0 || b_victim_way !== 3'd0) begin
      errors++;
      $display("FAIL drop_b: got vld=%b way=%0d want 0 0", b_evict_valid, b_victim_way);
    end
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ea = sb_a.pop_front();
        checks++;
        if (a_evict_valid !== 1'b1 || a_victim_way !== ea.way || a_victim_onehot !== (4'b0001 << ea.way) || a_victim_data !== ea.data) begin
          errors++;
          $display("FAIL post_reset_set%0d: got vld=%b way=%0d oh=%b data=%h want way=%0d data=%h", i-1, a_evict_valid, a_victim_way, a_victim_onehot, a_victim_data, ea.way, ea.data);
        end
      end
      if (i < 8) a_push_evict(i, 3);
      else a_evict_req = 1'b0;
      if (i == 0) b_push_evict(2, 7);
      if (i == 1) begin
        b_evict_req = 1'b0;
        eb = sb_b.pop_front();
        checks++;
        if (b_evict_valid !== 1'b1 || b_victim_way !== eb.way || b_victim_data !== eb.data) begin
          errors++;
          $display("FAIL post_reset_b: got vld=%b way=%0d data=%h want way=%0d data=%h", b_evict_valid, b_victim_way, b_victim_data, eb.way, eb.data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_victim();
    test_access_order();
    test_same_cycle();
    test_ways8();
    test_back_to_back();
    test_reset_drop();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
